// File: rtl/step_motor_ctrl_p.sv
// Stepper position controller: steps a 2-phase bipolar motor toward a signed target
// at a prescaled rate, in full- or half-step drive, with optional holding torque.
module step_motor_ctrl_p #(
  parameter int POS_W    = 14,
  parameter int DIV_W    = 19,
  parameter int STEP_DIV = 262144
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic signed [POS_W-1:0] target_in,
  input  logic                    home,
  input  logic                    half_mode,
  input  logic                    hold,
  output logic [3:0]              coils,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    done
);

  localparam logic [DIV_W-1:0]        LP_DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic signed [POS_W-1:0] LP_ONE      = POS_W'(1);
  localparam logic signed [POS_W-1:0] LP_ZERO     = '0;
  // Index parks one step behind p0 so the first step lands on p0 (half) or p1 (full).
  localparam logic [2:0]              LP_PHASE_RST = 3'd7;

  logic [DIV_W-1:0]        r_cnt;
  logic signed [POS_W-1:0] r_target;
  logic signed [POS_W-1:0] r_pos;
  logic [2:0]              r_phase;
  logic                    r_energised;
  logic                    r_done;
  logic [3:0]              r_coils;

  logic                    w_tick;
  logic                    w_at_target;
  logic                    w_fwd;
  logic                    w_step;
  logic                    w_idle;
  logic [2:0]              w_delta;
  logic [2:0]              w_phase_next;
  logic signed [POS_W-1:0] w_pos_next;
  logic signed [POS_W-1:0] w_target_next;

  function automatic logic [3:0] coil_lut(input logic [2:0] p);
    case (p)
      3'd0:    coil_lut = 4'b1000;
      3'd1:    coil_lut = 4'b1100;
      3'd2:    coil_lut = 4'b0100;
      3'd3:    coil_lut = 4'b0110;
      3'd4:    coil_lut = 4'b0010;
      3'd5:    coil_lut = 4'b0011;
      3'd6:    coil_lut = 4'b0001;
      default: coil_lut = 4'b1001;
    endcase
  endfunction

  assign w_tick        = en & (r_cnt == LP_DIV_LAST);
  assign w_at_target   = (r_pos == r_target);
  assign w_fwd         = (r_target > r_pos);
  assign w_step        = w_tick & ~w_at_target & ~home;
  assign w_idle        = w_at_target | ~en;
  assign w_target_next = load ? target_in : r_target;

  // Full-step moves from an even index go one slot, realigning onto two-coil phases.
  always_comb begin
    w_delta = 3'd0;
    if (half_mode)
      w_delta = w_fwd ? 3'd1 : 3'd7;
    else if (w_fwd)
      w_delta = r_phase[0] ? 3'd2 : 3'd1;
    else
      w_delta = r_phase[0] ? 3'd6 : 3'd7;
  end

  assign w_phase_next = w_step ? (r_phase + w_delta) : r_phase;

  always_comb begin
    w_pos_next = r_pos;
    if (home)
      w_pos_next = LP_ZERO;
    else if (w_step)
      w_pos_next = w_fwd ? (r_pos + LP_ONE) : (r_pos - LP_ONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_target    <= '0;
      r_pos       <= '0;
      r_phase     <= LP_PHASE_RST;
      r_energised <= 1'b0;
      r_done      <= 1'b0;
      r_coils     <= 4'b0000;
    end else begin
      if (!en || r_cnt == LP_DIV_LAST)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + DIV_W'(1);
      r_target <= w_target_next;
      r_pos    <= w_pos_next;
      r_phase  <= w_phase_next;
      r_done   <= w_step & (w_pos_next == w_target_next);
      if (w_step) begin
        r_energised <= 1'b1;
        r_coils     <= coil_lut(w_phase_next);
      end else if (w_idle && !hold) begin
        r_energised <= 1'b0;
        r_coils     <= 4'b0000;
      end else begin
        r_coils <= r_energised ? coil_lut(r_phase) : 4'b0000;
      end
    end
  end

  assign coils    = r_coils;
  assign position = r_pos;
  assign busy     = en & ~w_at_target;
  assign done     = r_done;

endmodule
